// File: rtl/estagio_busca_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Imported by estagio_busca and busca_buffer.
package estagio_busca_pkg;

  localparam int AW = 12;
  localparam int IW = 16;

  localparam logic [3:0]    OPC_JUMP = 4'd11;
  localparam logic [IW-1:0] NOP      = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DROP
  } state_t;

  function automatic logic [AW-1:0] pc_inc(
    input logic [AW-1:0] cur
  );
    return cur + 12'd1;
  endfunction

endpackage

// File: rtl/busca_buffer.sv
// One-entry skid buffer holding a fetched word and its address
// while the control stage is stalled.
module busca_buffer
  import estagio_busca_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          store,
  input  logic          drain,
  input  logic          flush,
  input  logic [IW-1:0] word_in,
  input  logic [AW-1:0] addr_in,
  output logic          full,
  output logic [IW-1:0] word,
  output logic [AW-1:0] addr
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      full <= 1'b0;
      word <= NOP;
      addr <= '0;
    end else if (store) begin
      full <= 1'b1;
      word <= word_in;
      addr <= addr_in;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/estagio_busca.sv
// Instruction fetch stage: IDLE/FETCH/DROP FSM with one-entry buffer.
// Optional STATIC_JUMP_EN follows opcode-11 jumps at capture time.
module estagio_busca
  import estagio_busca_pkg::*;
#(
  parameter logic [AW-1:0] RESET_PC = 12'h000,
  parameter logic [IW-1:0] NOP_WORD = NOP
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [IW-1:0] imem_data,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] pc,
  output logic          inst_valid
);

  state_t        state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] target;

  logic          buf_full;
  logic [IW-1:0] buf_word;
  logic [AW-1:0] buf_addr;

  logic          in_fetch;
  logic          take;
  logic          is_jump;
  logic [AW-1:0] seq_pc;
  logic          buf_store;
  logic          buf_drain;

  assign in_fetch = (state == S_FETCH);

  // DROP keeps the stale request alive so the memory can retire it
  assign imem_req  = (in_fetch && !buf_full)
                   || (state == S_DROP);
  assign imem_addr = fetch_pc;

  assign take = in_fetch && imem_req && imem_ready;

`ifdef STATIC_JUMP_EN
  assign is_jump = (imem_data[15:12] == OPC_JUMP);
`else
  assign is_jump = 1'b0;
`endif

  assign seq_pc = is_jump ? imem_data[AW-1:0]
                          : pc_inc(fetch_pc);

  assign buf_store = take && stall && !redirect;
  assign buf_drain = in_fetch && !redirect
                   && !stall && buf_full;

  busca_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .store   (buf_store),
    .drain   (buf_drain),
    .flush   (redirect),
    .word_in (imem_data),
    .addr_in (fetch_pc),
    .full    (buf_full),
    .word    (buf_word),
    .addr    (buf_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      target     <= RESET_PC;
      inst       <= NOP_WORD;
      pc         <= '0;
      inst_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (redirect) begin
            inst       <= NOP_WORD;
            inst_valid <= 1'b0;
            if (imem_req && !imem_ready) begin
              state  <= S_DROP;
              target <= redirect_pc;
            end else begin
              fetch_pc <= redirect_pc;
            end
          end else begin
            if (take) fetch_pc <= seq_pc;
            if (!stall) begin
              if (buf_full) begin
                inst       <= buf_word;
                pc         <= buf_addr;
                inst_valid <= 1'b1;
              end else if (take) begin
                inst       <= imem_data;
                pc         <= fetch_pc;
                inst_valid <= 1'b1;
              end else begin
                inst       <= NOP_WORD;
                inst_valid <= 1'b0;
              end
            end
          end
        end
        S_DROP: begin
          inst       <= NOP_WORD;
          inst_valid <= 1'b0;
          if (redirect) target <= redirect_pc;
          // the newest target wins even on the retiring cycle
          if (imem_ready) begin
            state    <= S_FETCH;
            fetch_pc <= redirect ? redirect_pc : target;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
